// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout, ALU op encodings, bubble constant.
package pipe_pkg;

  localparam int unsigned CTRL_W = 12;
  localparam int unsigned REG_W  = 5;

  // Bit positions inside the 12-bit control bundle
  localparam int unsigned CTRL_REGWRITE  = 11;
  localparam int unsigned CTRL_MEMREAD   = 10;
  localparam int unsigned CTRL_MEMWRITE  = 9;
  localparam int unsigned CTRL_MEMTOREG  = 8;
  localparam int unsigned CTRL_ALUSRCA   = 7;
  localparam int unsigned CTRL_ALUSRCB   = 6;
  localparam int unsigned CTRL_REGDST_HI = 5;
  localparam int unsigned CTRL_REGDST_LO = 4;
  localparam int unsigned CTRL_ALUOP_HI  = 3;
  localparam int unsigned CTRL_ALUOP_LO  = 1;
  localparam int unsigned CTRL_BRANCH    = 0;

  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'd0,
    ALUOP_SUB   = 3'd1,
    ALUOP_AND   = 3'd2,
    ALUOP_OR    = 3'd3,
    ALUOP_SLT   = 3'd4,
    ALUOP_SHIFT = 3'd5,
    ALUOP_LUI   = 3'd6,
    ALUOP_FUNCT = 3'd7
  } aluop_e;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 12'b0;

  // An invalid slot must never carry live control into EX
  function automatic logic [CTRL_W-1:0] ctrl_gate(input logic valid,
                                                  input logic [CTRL_W-1:0] ctrl);
    return valid ? ctrl : CTRL_BUBBLE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones, cleared only by reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with hazard stall/flush and a saturating bubble counter.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              Valid_ID,
  input  logic [DATA_W-1:0] PC4_ID,
  input  logic [DATA_W-1:0] ReadData1_ID,
  input  logic [DATA_W-1:0] ReadData2_ID,
  input  logic [DATA_W-1:0] ExtOut_ID,
  input  logic [REG_W-1:0]  Rs_ID,
  input  logic [REG_W-1:0]  Rt_ID,
  input  logic [REG_W-1:0]  Rd_ID,
  input  logic [REG_W-1:0]  Sa_ID,
  input  logic [CTRL_W-1:0] Ctrl_ID,
  output logic              Valid_EX,
  output logic [DATA_W-1:0] PC4_EX,
  output logic [DATA_W-1:0] ReadData1_EX,
  output logic [DATA_W-1:0] ReadData2_EX,
  output logic [DATA_W-1:0] ExtOut_EX,
  output logic [REG_W-1:0]  Rs_EX,
  output logic [REG_W-1:0]  Rt_EX,
  output logic [REG_W-1:0]  Rd_EX,
  output logic [REG_W-1:0]  Sa_EX,
  output logic [CTRL_W-1:0] Ctrl_EX,
  output logic [CNT_W-1:0]  BubbleCnt
);

  // A bubble enters EX on a flush, or on a normal capture of an invalid slot
  logic bubble_inc;
  assign bubble_inc = Flush | (~Stall & ~Valid_ID);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      Valid_EX     <= 1'b0;
      PC4_EX       <= '0;
      ReadData1_EX <= '0;
      ReadData2_EX <= '0;
      ExtOut_EX    <= '0;
      Rs_EX        <= '0;
      Rt_EX        <= '0;
      Rd_EX        <= '0;
      Sa_EX        <= '0;
      Ctrl_EX      <= CTRL_BUBBLE;
    end else if (Flush) begin
      Valid_EX     <= 1'b0;
      PC4_EX       <= '0;
      ReadData1_EX <= '0;
      ReadData2_EX <= '0;
      ExtOut_EX    <= '0;
      Rs_EX        <= '0;
      Rt_EX        <= '0;
      Rd_EX        <= '0;
      Sa_EX        <= '0;
      Ctrl_EX      <= CTRL_BUBBLE;
    end else if (!Stall) begin
      Valid_EX     <= Valid_ID;
      PC4_EX       <= PC4_ID;
      ReadData1_EX <= ReadData1_ID;
      ReadData2_EX <= ReadData2_ID;
      ExtOut_EX    <= ExtOut_ID;
      Rs_EX        <= Rs_ID;
      Rt_EX        <= Rt_ID;
      Rd_EX        <= Rd_ID;
      Sa_EX        <= Sa_ID;
      Ctrl_EX      <= ctrl_gate(Valid_ID, Ctrl_ID);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (CLK),
    .rst_n (Reset),
    .inc   (bubble_inc),
    .cnt   (BubbleCnt)
  );

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: driver queues expected EX contents, monitor pops and compares.
module tb_id_ex_pipe_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc4;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] ext;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    sa;
    logic [11:0]   ctrl;
  } slot_t;

  typedef struct {
    slot_t         s;
    logic [CW-1:0] cnt;
    string         tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic stall, flush;
  slot_t in_s;

  logic          Valid_EX;
  logic [DW-1:0] PC4_EX, ReadData1_EX, ReadData2_EX, ExtOut_EX;
  logic [4:0]    Rs_EX, Rt_EX, Rd_EX, Sa_EX;
  logic [11:0]   Ctrl_EX;
  logic [CW-1:0] BubbleCnt;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  event chk_now;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .CLK          (clk),
    .Reset        (rst_n),
    .Stall        (stall),
    .Flush        (flush),
    .Valid_ID     (in_s.valid),
    .PC4_ID       (in_s.pc4),
    .ReadData1_ID (in_s.rd1),
    .ReadData2_ID (in_s.rd2),
    .ExtOut_ID    (in_s.ext),
    .Rs_ID        (in_s.rs),
    .Rt_ID        (in_s.rt),
    .Rd_ID        (in_s.rd),
    .Sa_ID        (in_s.sa),
    .Ctrl_ID      (in_s.ctrl),
    .Valid_EX     (Valid_EX),
    .PC4_EX       (PC4_EX),
    .ReadData1_EX (ReadData1_EX),
    .ReadData2_EX (ReadData2_EX),
    .ExtOut_EX    (ExtOut_EX),
    .Rs_EX        (Rs_EX),
    .Rt_EX        (Rt_EX),
    .Rd_EX        (Rd_EX),
    .Sa_EX        (Sa_EX),
    .Ctrl_EX      (Ctrl_EX),
    .BubbleCnt    (BubbleCnt)
  );

  // Monitor: after each edge (or an out-of-band reset check) compare against the queue head
  initial begin
    exp_t  e;
    slot_t act;
    forever begin
      @(posedge clk or chk_now);
      #3;
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {Valid_EX, PC4_EX, ReadData1_EX, ReadData2_EX, ExtOut_EX,
               Rs_EX, Rt_EX, Rd_EX, Sa_EX, Ctrl_EX};
        vectors++;
        if (act !== e.s || BubbleCnt !== e.cnt) begin
          miscompares++;
          $display("FAIL %s: got slot=%h cnt=%0d, want slot=%h cnt=%0d",
                   e.tag, act, BubbleCnt, e.s, e.cnt);
        end
      end
    end
  end

  task automatic expect_now(input slot_t e, input logic [CW-1:0] c, input string tag);
    exp_t x;
    x.s = e; x.cnt = c; x.tag = tag;
    q.push_back(x);
  endtask

  // Drive one ID slot, and after the capturing edge queue the EX contents it must produce
  task automatic apply(input slot_t s, input logic st, input logic fl,
                       input slot_t e, input logic [CW-1:0] c, input string tag);
    in_s  = s;
    stall = st;
    flush = fl;
    @(posedge clk);
    expect_now(e, c, tag);
    #1;
  endtask

  // Assert reset between edges and check outputs before any edge arrives
  task automatic mid_cycle_reset(input string tag);
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    expect_now('0, '0, tag);
    ->chk_now;
    #4;
    rst_n = 1'b1;
  endtask

  initial begin
    slot_t s, e, held;
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    in_s  = '0;
    #1;
    expect_now('0, '0, "reset_state");
    ->chk_now;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal capture: immediate passed through bit-exact
    s = '{valid:1'b1, pc4:32'h0000_0100, rd1:32'h1111_1111, rd2:32'h2222_2222,
          ext:32'hFFFF_8000, rs:5'd3, rt:5'd9, rd:5'd17, sa:5'd5, ctrl:12'hA55};
    apply(s, 1'b0, 1'b0, s, 4'd0, "normal_capture");

    // Async reset mid-cycle with all-ones inputs, then first edge captures them
    in_s = '1;
    mid_cycle_reset("async_reset");
    s = '1;
    apply(s, 1'b0, 1'b0, s, 4'd0, "post_reset_capture");

    // Stall: hold 0x10 for three edges, then take 0x14
    s = '{valid:1'b1, pc4:32'h0000_0010, rd1:32'hDEAD_BEEF, rd2:32'h0BAD_F00D,
          ext:32'h0000_7FFF, rs:5'd1, rt:5'd2, rd:5'd3, sa:5'd31, ctrl:12'h801};
    apply(s, 1'b0, 1'b0, s, 4'd0, "load_pc10");
    held = s;
    s.pc4 = 32'h0000_0014;
    s.rd1 = 32'h5555_AAAA;
    apply(s, 1'b1, 1'b0, held, 4'd0, "stall_1");
    apply(s, 1'b1, 1'b0, held, 4'd0, "stall_2");
    apply(s, 1'b1, 1'b0, held, 4'd0, "stall_3");
    apply(s, 1'b0, 1'b0, s,    4'd0, "stall_release");

    // Flush beats stall
    s.ctrl = 12'hFFF;
    apply(s, 1'b1, 1'b1, '0, 4'd1, "flush_over_stall");

    // Invalid slot: control killed, data kept, bubble counted
    s = '{valid:1'b0, pc4:32'h0000_0040, rd1:32'h0000_1234, rd2:32'h0000_5678,
          ext:32'h0000_0042, rs:5'd4, rt:5'd5, rd:5'd6, sa:5'd7, ctrl:12'h800};
    e = s;
    e.ctrl = 12'h000;
    apply(s, 1'b0, 1'b0, e, 4'd2, "invalid_slot");

    // Stall with an invalid ID slot holds and does not count
    s.rd1 = 32'h0000_9999;
    apply(s, 1'b1, 1'b0, e, 4'd2, "stall_invalid_hold");

    s = '{valid:1'b1, pc4:32'h0000_0044, rd1:32'hCAFE_0001, rd2:32'h0000_0000,
          ext:32'hFFFF_FFFC, rs:5'd31, rt:5'd0, rd:5'd31, sa:5'd0, ctrl:12'h3C6};
    apply(s, 1'b0, 1'b0, s, 4'd2, "valid_after_bubble");

    // Saturation: clear counter, then 20 flushes
    mid_cycle_reset("reset_before_sat");
    s.ctrl = 12'hFFF;
    for (int k = 1; k <= 20; k++) begin
      apply(s, 1'b0, 1'b1, '0, (k > 15) ? 4'd15 : CW'(k), $sformatf("sat_flush_%0d", k));
    end
    apply(s, 1'b0, 1'b0, s, 4'd15, "sat_valid_capture");
    s.valid = 1'b0;
    e = s;
    e.ctrl = 12'h000;
    apply(s, 1'b0, 1'b0, e, 4'd15, "sat_invalid_no_wrap");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #5;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
